// File: rtl/aes_pkg.sv
// Constants and state encoding shared by the AES-128 UART message processors.
package aes_pkg;

  localparam int AES_BLOCK_BITS  = 128;
  localparam int BYTES_PER_BLOCK = 16;
  localparam int AES_DATA_WIDTH  = 32;

  function automatic int words_per_block(input int data_width);
    return AES_BLOCK_BITS / data_width;
  endfunction

  localparam int WORDS_PER_BLOCK = words_per_block(AES_DATA_WIDTH);

  typedef logic [2:0] mp_state_t;
  localparam mp_state_t MP_IDLE    = 3'd0;
  localparam mp_state_t MP_COLLECT = 3'd1;
  localparam mp_state_t MP_SEND    = 3'd2;
  localparam mp_state_t MP_WAIT_TX = 3'd3;
  localparam mp_state_t MP_DONE    = 3'd4;

endpackage

// File: rtl/mp_out_if.sv
// Ciphertext-in / UART-byte-out signal bundle of the output message processor.
interface mp_out_if
  import aes_pkg::*;
#(
  parameter int DATA_WIDTH = AES_DATA_WIDTH,
  parameter int BYTE_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] MP_cipher_in;
  logic                  MP_dv_in;
  logic                  TX_active_in;
  logic                  TX_done_in;
  logic [BYTE_WIDTH-1:0] uart_byte_out;
  logic                  TX_DV_out;
  logic                  MP_busy_out;
  logic                  MP_done_out;

  modport master (
    output MP_cipher_in, MP_dv_in, TX_active_in, TX_done_in,
    input  uart_byte_out, TX_DV_out, MP_busy_out, MP_done_out
  );

  modport slave (
    input  MP_cipher_in, MP_dv_in, TX_active_in, TX_done_in,
    output uart_byte_out, TX_DV_out, MP_busy_out, MP_done_out
  );

endinterface

// File: rtl/mp_out.sv
// Output message processor: collects one 128-bit ciphertext block and streams it
// to the UART transmitter MSB byte first.
//   state   | meaning
//   IDLE    | waiting for the first ciphertext word
//   COLLECT | capturing the remaining words of the block
//   SEND    | launching the top byte once the UART is free
//   WAIT_TX | byte in flight, waiting for the UART to finish it
//   DONE    | block fully sent, one-cycle done pulse
module mp_out
  import aes_pkg::*;
#(
  parameter int DATA_WIDTH = AES_DATA_WIDTH,
  parameter int BYTE_WIDTH = 8
) (
  input logic     clk,
  input logic     rst,
  mp_out_if.slave bus
);

  localparam int WORDS = words_per_block(DATA_WIDTH);
  localparam int WCW   = $clog2(WORDS);
  localparam int BCW   = $clog2(BYTES_PER_BLOCK);

  mp_state_t                 state_q, state_d;
  logic [AES_BLOCK_BITS-1:0] blk_q, blk_d;
  logic [AES_BLOCK_BITS-1:0] word_top;
  logic [WCW-1:0]            word_cnt_q, word_cnt_d;
  logic [BCW-1:0]            byte_cnt_q, byte_cnt_d;
  logic [BYTE_WIDTH-1:0]     byte_q, byte_d;
  logic                      tx_dv_q, tx_dv_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      last_word, last_byte;

  // Incoming word aligned to the top of the block; later words are shifted down into place.
  assign word_top  = {bus.MP_cipher_in, {(AES_BLOCK_BITS-DATA_WIDTH){1'b0}}};
  assign last_word = (word_cnt_q == WCW'(WORDS-1));
  assign last_byte = (byte_cnt_q == BCW'(BYTES_PER_BLOCK-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MP_IDLE;
      blk_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      byte_q     <= '0;
      tx_dv_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      byte_q     <= byte_d;
      tx_dv_q    <= tx_dv_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MP_IDLE:    if (bus.MP_dv_in) state_d = MP_COLLECT;
      MP_COLLECT: if (bus.MP_dv_in && last_word) state_d = MP_SEND;
      MP_SEND:    if (!bus.TX_active_in) state_d = MP_WAIT_TX;
      MP_WAIT_TX: if (bus.TX_done_in) state_d = last_byte ? MP_DONE : MP_SEND;
      MP_DONE:    state_d = MP_IDLE;
      default:    state_d = MP_IDLE;
    endcase
  end

  always_comb begin
    blk_d      = blk_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    byte_d     = byte_q;
    tx_dv_d    = 1'b0;
    case (state_q)
      MP_IDLE: begin
        word_cnt_d = '0;
        byte_cnt_d = '0;
        if (bus.MP_dv_in) begin
          blk_d      = word_top;
          word_cnt_d = WCW'(1);
        end
      end
      MP_COLLECT: begin
        if (bus.MP_dv_in) begin
          blk_d      = blk_q | (word_top >> (DATA_WIDTH * word_cnt_q));
          word_cnt_d = last_word ? '0 : word_cnt_q + 1'b1;
          byte_cnt_d = '0;
        end
      end
      MP_SEND: begin
        if (!bus.TX_active_in) begin
          byte_d  = blk_q[AES_BLOCK_BITS-1 -: BYTE_WIDTH];
          tx_dv_d = 1'b1;
        end
      end
      MP_WAIT_TX: begin
        if (bus.TX_done_in) begin
          blk_d      = blk_q << BYTE_WIDTH;
          byte_cnt_d = byte_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
    busy_d = (state_d != MP_IDLE);
    done_d = (state_d == MP_DONE);
  end

  assign bus.uart_byte_out = byte_q;
  assign bus.TX_DV_out     = tx_dv_q;
  assign bus.MP_busy_out   = busy_q;
  assign bus.MP_done_out   = done_q;

endmodule
